// File: rtl/vend_pkg.sv
// Shared coin encodings, unit values, controller state enum and greedy change selection
// for the multi-slot vending trade controller.
package vend_pkg;

  localparam logic [1:0] COIN_HALF = 2'd0;
  localparam logic [1:0] COIN_ONE  = 2'd1;
  localparam logic [1:0] COIN_FIVE = 2'd2;
  localparam logic [1:0] COIN_TEN  = 2'd3;

  localparam int unsigned UNITS_HALF = 1;
  localparam int unsigned UNITS_ONE  = 2;
  localparam int unsigned UNITS_FIVE = 10;
  localparam int unsigned UNITS_TEN  = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_CHANGE
  } state_t;

  function automatic logic [4:0] coin_units(input logic [1:0] t);
    case (t)
      COIN_HALF: return 5'(UNITS_HALF);
      COIN_ONE:  return 5'(UNITS_ONE);
      COIN_FIVE: return 5'(UNITS_FIVE);
      default:   return 5'(UNITS_TEN);
    endcase
  endfunction

  // Largest coin not exceeding the remaining balance; half-yuan when nothing larger fits.
  function automatic logic [1:0] greedy_coin(input logic [15:0] bal);
    if (bal >= 16'(UNITS_TEN))       return COIN_TEN;
    else if (bal >= 16'(UNITS_FIVE)) return COIN_FIVE;
    else if (bal >= 16'(UNITS_ONE))  return COIN_ONE;
    else                             return COIN_HALF;
  endfunction

endpackage

// File: rtl/vend_table.sv
// Per-slot price/stock register file: one write port, combinational price/stock read
// of a single slot, and a decrement of that same slot's stock.
module vend_table
  import vend_pkg::*;
#(
  parameter int GOODS_N = 12,
  parameter int IDX_W   = 4,
  parameter int PRICE_W = 6,
  parameter int STOCK_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [PRICE_W-1:0] wprice,
  input  logic [STOCK_W-1:0] wstock,
  input  logic [IDX_W-1:0]   raddr,
  output logic [PRICE_W-1:0] rprice,
  output logic [STOCK_W-1:0] rstock,
  input  logic               dec
);

  logic [PRICE_W-1:0] price_q [GOODS_N];
  logic [STOCK_W-1:0] stock_q [GOODS_N];

  // Slot 0 is never written or read, so it stays at its reset value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < GOODS_N; i++) begin
        price_q[i] <= '0;
        stock_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < GOODS_N; i++) begin
        if (we && waddr == IDX_W'(i)) begin
          price_q[i] <= wprice;
          stock_q[i] <= wstock;
        end else if (dec && raddr == IDX_W'(i)) begin
          stock_q[i] <= stock_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    rprice = '0;
    rstock = '0;
    for (int unsigned i = 1; i < GOODS_N; i++) begin
      if (raddr == IDX_W'(i)) begin
        rprice = price_q[i];
        rstock = stock_q[i];
      end
    end
  end

endmodule

// File: rtl/vend_trade_mc.sv
// Multi-slot, multi-quantity vending trade controller with greedy coin change.
// Define VEND_TIMEOUT_EN to enable the COLLECT inactivity auto-refund.
module vend_trade_mc
  import vend_pkg::*;
#(
  parameter int GOODS_N = 12,
  parameter int IDX_W   = 4,
  parameter int MONEY_W = 8,
  parameter int PRICE_W = 6,
  parameter int STOCK_W = 4,
  parameter int QTY_W   = 2
`ifdef VEND_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1000000
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               coin_valid,
  input  logic [1:0]         coin_type,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   sel_index,
  input  logic [QTY_W-1:0]   sel_qty,
  input  logic               buy_req,
  input  logic               cancel_req,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [PRICE_W-1:0] cfg_price,
  input  logic [STOCK_W-1:0] cfg_stock,
  output logic [MONEY_W-1:0] balance,
  output logic               enough,
  output logic               coin_reject,
  output logic               vend_valid,
  output logic [IDX_W-1:0]   vend_index,
  input  logic               vend_ack,
  output logic               chg_valid,
  output logic [1:0]         chg_type,
  input  logic               chg_ack,
  output logic               busy,
  output logic               err
);

  localparam int COST_W = PRICE_W + QTY_W;
  localparam int CMP_W  = (MONEY_W > COST_W) ? MONEY_W : COST_W;

  state_t             state_q, state_d;
  logic [MONEY_W-1:0] bal_q, bal_d;
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
  logic [QTY_W-1:0]   sel_qty_q, sel_qty_d;
  logic [QTY_W-1:0]   rem_q, rem_d;
  logic               err_q, err_d;
  logic               rej_q, rej_d;

  logic [PRICE_W-1:0] price;
  logic [STOCK_W-1:0] stock;
  logic [QTY_W-1:0]   qty_eff;
  logic [COST_W-1:0]  cost;
  logic [MONEY_W:0]   credit;
  logic [1:0]         chg_coin;
  logic [MONEY_W-1:0] vend_left, chg_left;
  logic               slot_ok, enough_w, coin_take, sel_take, tmo_hit;

  vend_table #(
    .GOODS_N(GOODS_N),
    .IDX_W  (IDX_W),
    .PRICE_W(PRICE_W),
    .STOCK_W(STOCK_W)
  ) u_table (
    .clk   (clk),
    .rstn  (rstn),
    .we    (cfg_we && state_q == ST_IDLE),
    .waddr (cfg_addr),
    .wprice(cfg_price),
    .wstock(cfg_stock),
    .raddr (sel_idx_q),
    .rprice(price),
    .rstock(stock),
    .dec   (vend_ack && state_q == ST_VEND)
  );

  assign qty_eff   = (sel_qty_q == '0) ? QTY_W'(1) : sel_qty_q;
  assign cost      = COST_W'(price) * COST_W'(qty_eff);
  assign slot_ok   = (sel_idx_q != '0) && (32'(sel_idx_q) < 32'(GOODS_N));
  assign enough_w  = slot_ok && (CMP_W'(bal_q) >= CMP_W'(cost)) && (32'(stock) >= 32'(qty_eff));
  assign credit    = {1'b0, bal_q} + (MONEY_W + 1)'(coin_units(coin_type));
  assign chg_coin  = greedy_coin(16'(bal_q));
  assign vend_left = bal_q - MONEY_W'(price);
  assign chg_left  = bal_q - MONEY_W'(coin_units(chg_coin));
  assign sel_take  = sel_valid && (state_q == ST_IDLE || state_q == ST_COLLECT);

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             activity;

  assign activity = coin_valid || sel_valid || buy_req;
  assign tmo_hit  = (state_q == ST_COLLECT) && !activity && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (state_q == ST_COLLECT && !activity) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      bal_q     <= '0;
      sel_idx_q <= '0;
      sel_qty_q <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bal_q     <= bal_d;
      sel_idx_q <= sel_idx_d;
      sel_qty_q <= sel_qty_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      rej_q     <= rej_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    sel_idx_d = sel_idx_q;
    sel_qty_d = sel_qty_q;
    rem_d     = rem_q;
    err_d     = err_q;
    coin_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        coin_take = coin_valid && !credit[MONEY_W];
        if (coin_take) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        // A coin only lands when neither cancel nor buy claims the cycle.
        coin_take = coin_valid && !cancel_req && !buy_req && !credit[MONEY_W];
        if (cancel_req) begin
          state_d = ST_CHANGE;
        end else if (buy_req) begin
          if (enough_w) begin
            state_d = ST_VEND;
            rem_d   = qty_eff;
          end
        end else if (tmo_hit) begin
          state_d = ST_CHANGE;
        end
      end
      ST_VEND: begin
        if (vend_ack) begin
          bal_d = vend_left;
          rem_d = rem_q - 1'b1;
          if (rem_q == QTY_W'(1)) state_d = (vend_left != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (bal_q == '0) begin
          state_d = ST_IDLE;
        end else if (chg_ack) begin
          bal_d = chg_left;
          if (chg_left == '0) state_d = ST_IDLE;
        end
      end
    endcase
    if (coin_take) bal_d = credit[MONEY_W-1:0];
    rej_d = coin_valid && !coin_take;
    if (sel_take) begin
      sel_idx_d = sel_index;
      sel_qty_d = sel_qty;
    end
    if (sel_take || coin_take) err_d = 1'b0;
    if (state_q == ST_COLLECT && !cancel_req && buy_req && !enough_w) err_d = 1'b1;
  end

  always_comb begin
    balance     = bal_q;
    enough      = enough_w;
    coin_reject = rej_q;
    err         = err_q;
    busy        = (state_q == ST_VEND) || (state_q == ST_CHANGE);
    vend_valid  = (state_q == ST_VEND);
    vend_index  = vend_valid ? sel_idx_q : '0;
    chg_valid   = (state_q == ST_CHANGE) && (bal_q != '0);
    chg_type    = chg_valid ? chg_coin : 2'd0;
  end

endmodule

// File: tb/tb_vend_trade_mc.sv
// Scoreboard bench for vend_trade_mc: stimulus queues expected reject/vend/change events,
// a negedge monitor pops and compares them as the DUT presents each one.
module tb_vend_trade_mc;

  localparam int EV_REJ  = 0;
  localparam int EV_VEND = 1;
  localparam int EV_CHG  = 2;

  typedef struct {
    int    kind;
    int    val;
    string name;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       coin_valid, sel_valid, buy_req, cancel_req, cfg_we;
  logic [1:0] coin_type;
  logic [3:0] sel_index, cfg_addr;
  logic [1:0] sel_qty;
  logic [5:0] cfg_price;
  logic [3:0] cfg_stock;
  logic [7:0] balance;
  logic       enough, coin_reject, vend_valid, chg_valid, busy, err;
  logic [3:0] vend_index;
  logic [1:0] chg_type;
  logic       vend_ack, chg_ack;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  vend_trade_mc #(
    .GOODS_N(12),
    .IDX_W  (4),
    .MONEY_W(8),
    .PRICE_W(6),
    .STOCK_W(4),
    .QTY_W  (2)
`ifdef VEND_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .sel_valid  (sel_valid),
    .sel_index  (sel_index),
    .sel_qty    (sel_qty),
    .buy_req    (buy_req),
    .cancel_req (cancel_req),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_price  (cfg_price),
    .cfg_stock  (cfg_stock),
    .balance    (balance),
    .enough     (enough),
    .coin_reject(coin_reject),
    .vend_valid (vend_valid),
    .vend_index (vend_index),
    .vend_ack   (vend_ack),
    .chg_valid  (chg_valid),
    .chg_type   (chg_type),
    .chg_ack    (chg_ack),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic expect_ev(input int kind, input int val, input string name);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d value %0d expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        bad++;
        $display("FAIL %s: got kind %0d value %0d expected kind %0d value %0d",
                 e.name, kind, val, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (coin_reject)            pop_check(EV_REJ, int'(balance));
      if (vend_valid && vend_ack) pop_check(EV_VEND, int'(vend_index));
      if (chg_valid && chg_ack)   pop_check(EV_CHG, int'(chg_type));
    end
  end

  // Dispenser and hopper models: acknowledge every other cycle while a request is up.
  initial begin
    vend_ack = 1'b0;
    chg_ack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vend_ack = vend_valid && !vend_ack;
      chg_ack  = chg_valid && !chg_ack;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [3:0] idx, input logic [1:0] qty);
    sel_valid = 1'b1;
    sel_index = idx;
    sel_qty   = qty;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] a, input logic [5:0] p, input logic [3:0] s);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_price = p;
    cfg_stock = s;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic buy();
    buy_req = 1'b1;
    tick();
    buy_req = 1'b0;
  endtask

  task automatic cancel();
    cancel_req = 1'b1;
    tick();
    cancel_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || balance != 8'd0) && n < 500) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, (n < 500) ? 1 : 0, 1);
    tick();
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_balance_zero"}, int'(balance), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    rstn       = 1'b0;
    coin_valid = 1'b0;
    coin_type  = 2'd0;
    sel_valid  = 1'b0;
    sel_index  = '0;
    sel_qty    = '0;
    buy_req    = 1'b0;
    cancel_req = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_price  = '0;
    cfg_stock  = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();

    check("rst_balance", int'(balance), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_enough", int'(enough), 0);
    check("rst_vend_valid", int'(vend_valid), 0);
    check("rst_chg_valid", int'(chg_valid), 0);
    check("rst_coin_reject", int'(coin_reject), 0);

    // Table setup; slot 0 and slot 12 writes must be dropped.
    cfg(4'd4, 6'd4, 4'd2);
    cfg(4'd2, 6'd3, 4'd5);
    cfg(4'd0, 6'd1, 4'd9);
    cfg(4'd12, 6'd1, 4'd9);

    // Single purchase with half-yuan change.
    coin(2'd1);
    coin(2'd1);
    coin(2'd0);
    check("t1_balance5", int'(balance), 5);
    sel(4'd4, 2'd1);
    check("t1_enough", int'(enough), 1);
    expect_ev(EV_VEND, 4, "t1_vend");
    expect_ev(EV_CHG, 0, "t1_chg_half");
    buy();
    check("t1_busy", int'(busy), 1);
    wait_idle("t1");

    // Refused buy on stock, err set/clear, ignored cfg while collecting.
    coin(2'd2);
    check("t2_balance10", int'(balance), 10);
    cfg(4'd4, 6'd4, 4'd15);
    sel(4'd4, 2'd1);
    check("t2_enough_q1", int'(enough), 1);
    sel(4'd4, 2'd0);
    check("t2_enough_q0", int'(enough), 1);
    sel(4'd4, 2'd2);
    check("t2_enough_stock", int'(enough), 0);
    sel(4'd4, 2'd3);
    buy();
    check("t2_err_set", int'(err), 1);
    check("t2_not_busy", int'(busy), 0);
    check("t2_balance_kept", int'(balance), 10);
    sel(4'd0, 2'd1);
    check("t2_err_clr_sel", int'(err), 0);
    check("t2_enough_slot0", int'(enough), 0);
    buy();
    check("t2_err_set2", int'(err), 1);
    coin(2'd0);
    check("t2_err_clr_coin", int'(err), 0);
    check("t2_balance11", int'(balance), 11);
    sel(4'd12, 2'd1);
    check("t2_enough_slot12", int'(enough), 0);
    expect_ev(EV_CHG, 2, "t2_chg_five");
    expect_ev(EV_CHG, 0, "t2_chg_half");
    cancel();
    wait_idle("t2");

    // Overflow boundary at 255 and greedy refund of a full balance.
    for (int i = 0; i < 12; i++) coin(2'd3);
    coin(2'd2);
    check("t3_balance250", int'(balance), 250);
    expect_ev(EV_REJ, 250, "t3_rej_five");
    coin(2'd2);
    check("t3_balance_held", int'(balance), 250);
    coin(2'd1);
    coin(2'd1);
    coin(2'd0);
    check("t3_balance255", int'(balance), 255);
    expect_ev(EV_REJ, 255, "t3_rej_half");
    coin(2'd0);
    expect_ev(EV_REJ, 255, "t3_rej_ten");
    coin(2'd3);
    check("t3_balance255_held", int'(balance), 255);
    for (int i = 0; i < 12; i++) expect_ev(EV_CHG, 3, "t3_chg_ten");
    expect_ev(EV_CHG, 2, "t3_chg_five");
    expect_ev(EV_CHG, 1, "t3_chg_one_a");
    expect_ev(EV_CHG, 1, "t3_chg_one_b");
    expect_ev(EV_CHG, 0, "t3_chg_half");
    cancel();
    wait_idle("t3");

    // Two-item purchase; the coin arriving with buy is refused.
    coin(2'd3);
    check("t4_balance20", int'(balance), 20);
    sel(4'd2, 2'd2);
    check("t4_enough", int'(enough), 1);
    expect_ev(EV_REJ, 20, "t4_rej_with_buy");
    expect_ev(EV_VEND, 2, "t4_vend_a");
    expect_ev(EV_VEND, 2, "t4_vend_b");
    expect_ev(EV_CHG, 2, "t4_chg_five");
    expect_ev(EV_CHG, 1, "t4_chg_one_a");
    expect_ev(EV_CHG, 1, "t4_chg_one_b");
    buy_req    = 1'b1;
    coin_valid = 1'b1;
    coin_type  = 2'd0;
    tick();
    buy_req    = 1'b0;
    coin_valid = 1'b0;
    wait_idle("t4");
    coin(2'd3);
    sel(4'd2, 2'd3);
    check("t4_stock3_enough", int'(enough), 1);
    expect_ev(EV_CHG, 3, "t4b_chg_ten");
    cancel();
    wait_idle("t4b");

    // Coin together with cancel: refused, only prior credit refunded.
    coin(2'd1);
    check("t5_balance2", int'(balance), 2);
    expect_ev(EV_REJ, 2, "t5_rej_with_cancel");
    expect_ev(EV_CHG, 1, "t5_chg_one");
    cancel_req = 1'b1;
    coin_valid = 1'b1;
    coin_type  = 2'd3;
    tick();
    cancel_req = 1'b0;
    coin_valid = 1'b0;
    wait_idle("t5");

`ifdef VEND_TIMEOUT_EN
    coin(2'd1);
    repeat (50) tick();
    check("t6_still_collect", int'(busy), 0);
    check("t6_balance2", int'(balance), 2);
    expect_ev(EV_CHG, 1, "t6_timeout_chg_one");
    wait_idle("t6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
